// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: data width, FSM state encoding
// and the index-width helper used by the top and the round-robin picker.
package uart_tx_arbiter_pkg;

  localparam int DATA_W = 8;

  // Prefixed so they never collide with the UART_TX/UART_RX state names.
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LOAD      = 2'd1,
    ARB_WAIT_DONE = 2'd2,
    ARB_RELEASE   = 2'd3
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N_REQ. Reports the winner as one-hot plus binary index.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no path leaves one
    // unassigned; without these the tool would infer latches.
    cand       = 0;
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_valid && req[cand]) begin
        win_valid        = 1'b1;
        win_idx          = IDX_W'(cand);
        win_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among N_REQ byte producers: latches the
// winner's byte, pulses tx_start, waits for tx_done (or watchdog), then acks.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [DATA_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          ack,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [DATA_W-1:0]         tx_d_in,
  output logic                      tx_start,
  input  logic                      tx_done
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_d_in_q, tx_d_in_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [TO_W-1:0]   wd_q, wd_d;

  logic [N_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              win_valid;

  uart_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    err_d      = 1'b0;
    tx_start_d = 1'b0;
    tx_d_in_d  = tx_d_in_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d    = ARB_LOAD;
          grant_d    = win_onehot;
          idx_d      = win_idx;
          tx_d_in_d  = req_data[DATA_W*int'(win_idx) +: DATA_W];
          tx_start_d = 1'b1;
        end
      end
      ARB_LOAD: begin
        state_d = ARB_WAIT_DONE;
        wd_d    = '0;
      end
      ARB_WAIT_DONE: begin
        // tx_done is checked first so it wins over a simultaneous watchdog expiry.
        if (tx_done) begin
          state_d = ARB_RELEASE;
          grant_d = '0;
          ack_d   = grant_q;
        end else if (wd_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = ARB_RELEASE;
          grant_d = '0;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
        ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, and all state uses non-blocking
    // assignments so every flop sees the pre-edge values of the others.
    if (reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_d_in_q  <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      tx_d_in_q  <= tx_d_in_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      wd_q       <= wd_d;
    end
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign tx_start    = tx_start_q;
  assign tx_d_in     = tx_d_in_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of single arbitrations plus
// hand-written sequences for round-robin, watchdog, stray tx_done and reset.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int TOW = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  tx_d_in;
  logic        tx_start;
  logic        tx_done;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TO),
    .TO_W        (TOW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .tx_d_in     (tx_d_in),
    .tx_start    (tx_start),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          exp_idx;
    logic [7:0]  exp_byte;
    int          dly;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] byte_v;
  } exp_t;

  vec_t vecs [8];
  exp_t sb_q [$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   model_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_model(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic await_load();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 32 && !seen; c++) begin
      step();
      if (tx_start) seen = 1'b1;
    end
    check("load_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_load(output int idx);
    exp_t e;
    e.idx    = -1;
    e.byte_v = 8'h00;
    check("sb_has_entry", {31'd0, sb_q.size() > 0}, 32'd1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check("load_grant", grant, (e.idx >= 0) ? (32'd1 << e.idx) : 32'd0);
    check("load_d_in", tx_d_in, e.byte_v);
    check("load_busy", busy, 32'd1);
    idx = e.idx;
  endtask

  // Called at the LOAD sample; returns at the RELEASE sample.
  task automatic finish_tx(input int idx, input int dly, input logic [7:0] exp_b);
    step();
    for (int c = 0; c < dly; c++) begin
      check("wait_d_in_held", tx_d_in, exp_b);
      step();
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("rel_ack", ack, 32'd1 << idx);
    check("rel_grant", grant, 32'd0);
    check("rel_err", timeout_err, 32'd0);
    check("rel_d_in", tx_d_in, exp_b);
    model_ptr = (idx + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx;

    //        req      data            idx  byte   dly
    vecs[0] = '{4'b0100, 32'h11A5_2233, 2, 8'hA5, 0};
    vecs[1] = '{4'b0011, 32'h4455_6677, 0, 8'h77, 3};
    vecs[2] = '{4'b1001, 32'h8899_AABB, 3, 8'h88, 1};
    vecs[3] = '{4'b1010, 32'hCCDD_EEFF, 1, 8'hEE, 5};
    vecs[4] = '{4'b0010, 32'h0102_0304, 1, 8'h03, 2};
    vecs[5] = '{4'b1101, 32'h1122_3344, 2, 8'h22, 0};
    vecs[6] = '{4'b1000, 32'hDEAD_BEEF, 3, 8'hDE, 4};
    vecs[7] = '{4'b0001, 32'hCAFE_F00D, 0, 8'h0D, 1};

    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    tx_done  = 1'b0;
    step();
    step();
    check("rst_grant", grant, 32'd0);
    check("rst_ack", ack, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_err", timeout_err, 32'd0);
    check("rst_tx_start", tx_start, 32'd0);
    check("rst_d_in", tx_d_in, 32'd0);
    reset = 1'b0;

    for (int c = 0; c < 50; c++) begin
      step();
      check("idle_quiet", {grant, busy, tx_start}, 32'd0);
    end

    // Table: one arbitration per entry, inputs scrambled after the grant.
    for (int v = 0; v < 8; v++) begin
      req      = vecs[v].req;
      req_data = vecs[v].data;
      sb_q.push_back('{vecs[v].exp_idx, vecs[v].exp_byte});
      await_load();
      check_load(idx);
      req_data = ~vecs[v].data;
      req      = ~vecs[v].req;
      finish_tx(idx, vecs[v].dly, vecs[v].exp_byte);
      req = 4'b0000;
      step();
      check("post_idle", {ack, busy}, 32'd0);
    end

    // All requesters held: strict rotation from a freshly reset pointer.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    model_ptr = 0;
    req       = 4'b1111;
    req_data  = 32'h3322_1100;
    begin
      int p;
      int i;
      p = model_ptr;
      for (int g = 0; g < 5; g++) begin
        i = rr_model(4'b1111, p);
        sb_q.push_back('{i, 8'(i * 8'h11)});
        p = (i + 1) % N;
      end
    end
    for (int g = 0; g < 5; g++) begin
      await_load();
      check_load(idx);
      finish_tx(idx, 2, 8'(idx * 8'h11));
    end
    req = 4'b0000;
    step();

    // Watchdog: tx_done stuck low.
    req      = 4'b0001;
    req_data = 32'h0000_005A;
    sb_q.push_back('{rr_model(4'b0001, model_ptr), 8'h5A});
    await_load();
    check_load(idx);
    for (int c = 1; c <= TO; c++) begin
      step();
      check("wd_quiet", {ack, timeout_err}, 32'd0);
    end
    step();
    check("wd_err", timeout_err, 32'd1);
    check("wd_ack", ack, 32'd0);
    check("wd_grant", grant, 32'd0);
    model_ptr = (idx + 1) % N;
    req = 4'b0000;
    step();
    check("wd_err_pulse", {timeout_err, busy}, 32'd0);

    req      = 4'b0010;
    req_data = 32'h0000_C300;
    sb_q.push_back('{rr_model(4'b0010, model_ptr), 8'hC3});
    await_load();
    check_load(idx);
    finish_tx(idx, 1, 8'hC3);
    req = 4'b0000;
    step();

    // Stray tx_done during LOAD must be ignored.
    req      = 4'b0100;
    req_data = 32'h0077_0000;
    sb_q.push_back('{rr_model(4'b0100, model_ptr), 8'h77});
    await_load();
    check_load(idx);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stray_no_ack", ack, 32'd0);
      check("stray_busy", busy, 32'd1);
      check("stray_grant", grant, 32'd1 << idx);
      step();
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("stray_ack", ack, 32'd1 << idx);
    model_ptr = (idx + 1) % N;
    req = 4'b0000;
    step();

    // tx_done on the last watchdog cycle: ack wins, no error.
    req      = 4'b1000;
    req_data = 32'h9900_0000;
    sb_q.push_back('{rr_model(4'b1000, model_ptr), 8'h99});
    await_load();
    check_load(idx);
    for (int c = 1; c <= TO; c++) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("tie_ack", ack, 32'd1 << idx);
    check("tie_err", timeout_err, 32'd0);
    model_ptr = (idx + 1) % N;
    req = 4'b0000;
    step();
    check("tie_err_after", timeout_err, 32'd0);

    // Move the pointer off zero so a missed pointer reset is visible.
    req      = 4'b0001;
    req_data = 32'h0000_0042;
    sb_q.push_back('{rr_model(4'b0001, model_ptr), 8'h42});
    await_load();
    check_load(idx);
    finish_tx(idx, 0, 8'h42);
    req = 4'b0000;
    step();

    // Reset in WAIT_DONE: silent abort, pointer back to 0.
    req      = 4'b0100;
    req_data = 32'h00E1_0000;
    sb_q.push_back('{rr_model(4'b0100, model_ptr), 8'hE1});
    await_load();
    check_load(idx);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b0000;
    model_ptr = 0;
    sb_q.delete();
    check("mid_rst_grant", grant, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_tx_start", tx_start, 32'd0);
    check("mid_rst_d_in", tx_d_in, 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("mid_rst_quiet", {ack, timeout_err}, 32'd0);
      step();
    end
    req      = 4'b1001;
    req_data = 32'hB000_00B1;
    sb_q.push_back('{rr_model(4'b1001, model_ptr), 8'hB1});
    await_load();
    check_load(idx);
    finish_tx(idx, 2, 8'hB1);
    req = 4'b0000;
    step();
    check("final_idle", {grant, busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
